// File: rtl/vreg_load_seq.sv
// Vector register load/dump sequencer: streams elements into a staging vector and
// commits it to one of R registers, or streams a selected register back out.
module vreg_load_seq #(
    parameter int BITS = 8,
    parameter int N    = 64,
    parameter int R    = 4,
    localparam int RW  = (R > 1) ? $clog2(R) : 1,
    localparam int CW  = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_op,
    input  logic [RW-1:0]   cmd_reg,
    input  logic [BITS-1:0] in_data,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [BITS-1:0] stage [N-1:0],
    output logic [R-1:0]    reg_wr,
    output logic [RW-1:0]   rd_sel,
    input  logic [BITS-1:0] vec_in [N-1:0],
    output logic [BITS-1:0] out_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            done,
    output logic            err
);

    typedef enum logic [1:0] {IDLE, LOAD, COMMIT, DUMP} state_t;

    localparam logic [RW:0]   RLIM = (RW+1)'(R);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t        state, nxt;
    logic [CW-1:0] cnt;
    logic [RW-1:0] ri;
    logic          cmd_acc, reg_ok, in_hs, out_hs;

    assign reg_ok   = {1'b0, cmd_reg} < RLIM;
    assign cmd_acc  = cmd_valid & cmd_ready;
    assign in_hs    = in_valid & in_ready;
    assign out_hs   = out_valid & out_ready;
    assign rd_sel   = ri;
    assign out_data = vec_in[cnt];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt       = state;
        cmd_ready = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        done      = 1'b0;
        reg_wr    = '0;
        case (state)
            IDLE: begin
                cmd_ready = ~rst;
                if (cmd_valid && !rst && reg_ok)
                    nxt = cmd_op ? DUMP : LOAD;
            end
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid && cnt == LAST) nxt = COMMIT;
            end
            COMMIT: begin
                reg_wr[ri] = 1'b1;
                done       = 1'b1;
                nxt        = IDLE;
            end
            DUMP: begin
                out_valid = 1'b1;
                if (out_ready && cnt == LAST) begin
                    done = 1'b1;
                    nxt  = IDLE;
                end
            end
            default: nxt = IDLE;
        endcase
    end

    // A rejected index leaves ri alone so rd_sel never points past the register file.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            ri  <= '0;
            err <= 1'b0;
            for (int i = 0; i < N; i++) stage[i] <= '0;
        end else begin
            err <= 1'b0;
            if (cmd_acc) begin
                cnt <= '0;
                if (reg_ok) ri  <= cmd_reg;
                else        err <= 1'b1;
            end
            if (in_hs) stage[cnt] <= in_data;
            if (in_hs || out_hs) cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_vreg_load_seq.sv
// Scoreboard bench for vreg_load_seq: N=4 with R=4 (main) and R=3 (index range error).
module tb_vreg_load_seq;
    localparam int BITS = 8, N = 4;

    logic            clk = 0, rst = 1;
    logic            cmd_valid = 0, cmd_op = 0, in_valid = 0, out_ready = 1;
    logic [1:0]      cmd_reg = 0;
    logic [BITS-1:0] in_data = 0;
    logic [BITS-1:0] vec_in [N-1:0];

    logic            cmd_ready, in_ready, out_valid, done, err;
    logic [BITS-1:0] stage [N-1:0];
    logic [3:0]      reg_wr;
    logic [1:0]      rd_sel;
    logic [BITS-1:0] out_data;

    logic            cmd_ready3, in_ready3, out_valid3, done3, err3;
    logic [BITS-1:0] stage3 [N-1:0];
    logic [2:0]      reg_wr3;
    logic [1:0]      rd_sel3;
    logic [BITS-1:0] out_data3;

    vreg_load_seq #(.BITS(BITS), .N(N), .R(4)) u4 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_reg(cmd_reg), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .stage(stage), .reg_wr(reg_wr), .rd_sel(rd_sel),
        .vec_in(vec_in), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .done(done), .err(err));

    vreg_load_seq #(.BITS(BITS), .N(N), .R(3)) u3 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready3),
        .cmd_op(cmd_op), .cmd_reg(cmd_reg), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready3), .stage(stage3), .reg_wr(reg_wr3), .rd_sel(rd_sel3),
        .vec_in(vec_in), .out_data(out_data3), .out_valid(out_valid3),
        .out_ready(out_ready), .done(done3), .err(err3));

    always #5 clk = ~clk;

    int checks = 0, errors = 0, wr_cnt = 0, done_cnt = 0;
    int          exp_out [$];
    int          exp_wr  [$];
    logic [31:0] exp_stg [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] stg_packed();
        return {stage[3], stage[2], stage[1], stage[0]};
    endfunction

    // Scoreboard: commits and dump beats are matched against queued expectations.
    always @(negedge clk) begin
        if (!rst) begin
            if (done) done_cnt++;
            if (reg_wr != 0) begin
                wr_cnt++;
                if (exp_wr.size() == 0) chk("wr_unexpected", 32'(reg_wr), 0);
                else begin
                    chk("commit_wr", 32'(reg_wr), 32'(1 << exp_wr.pop_front()));
                    chk("commit_stage", stg_packed(), exp_stg.pop_front());
                end
            end
            if (out_valid && out_ready) begin
                if (exp_out.size() == 0) chk("out_unexpected", 32'(out_data), 0);
                else begin
                    chk("out_data", 32'(out_data), 32'(exp_out.pop_front()));
                    chk("dump_done", 32'(done), 32'(exp_out.size() == 0));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic op, input logic [1:0] r);
        cmd_valid = 1; cmd_op = op; cmd_reg = r;
        step();
        cmd_valid = 0;
    endtask

    task automatic load(input logic [1:0] r, input logic [31:0] v, input bit toggle);
        int ncyc;
        exp_wr.push_back(int'(r));
        exp_stg.push_back(v);
        send_cmd(0, r);
        chk("load_cmd_ready", 32'(cmd_ready), 0);
        ncyc = toggle ? 7 : 4;
        for (int c = 0; c < ncyc; c++) begin
            in_valid = toggle ? ((c % 2) == 0) : 1'b1;
            in_data  = v[8*(toggle ? c/2 : c) +: 8];
            chk("in_ready", 32'(in_ready), 1);
            chk("no_early_wr", 32'(reg_wr), 0);
            step();
        end
        in_valid = 0;
        chk("commit_now", 32'(reg_wr), 32'(1 << r));
        chk("commit_done", 32'(done), 1);
        step();
        chk("wr_single", 32'(reg_wr), 0);
        chk("idle_again", 32'(cmd_ready), 1);
    endtask

    task automatic dump(input logic [1:0] r, input int stall);
        for (int i = 0; i < N; i++) exp_out.push_back(10 * (i + 1));
        out_ready = (stall == 0);
        send_cmd(1, r);
        chk("rd_sel", 32'(rd_sel), 32'(r));
        chk("out_valid", 32'(out_valid), 1);
        for (int i = 0; i < stall; i++) begin
            chk("stall_data", 32'(out_data), 10);
            step();
        end
        chk("stall_hold", 32'(out_data), 10);
        out_ready = 1;
        repeat (N) step();
        chk("dump_end_valid", 32'(out_valid), 0);
        chk("dump_drained", 32'(exp_out.size()), 0);
    endtask

    initial begin
        for (int i = 0; i < N; i++) vec_in[i] = BITS'(10 * (i + 1));
        #3;
        chk("rst_cmd_ready", 32'(cmd_ready), 0);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_reg_wr", 32'(reg_wr), 0);
        chk("rst_done_err", 32'({done, err}), 0);
        chk("rst_stage", stg_packed(), 0);
        step(); step();
        rst = 0;
        step();
        chk("idle_ready", 32'(cmd_ready), 1);

        load(2'd2, 32'h04030201, 0);
        chk("stage_hold", stg_packed(), 32'h04030201);
        load(2'd0, 32'h08070605, 1);
        dump(2'd1, 0);
        dump(2'd3, 5);

        // R=3 instance rejects index 3; the R=4 instance takes it as a LOAD.
        send_cmd(0, 2'd3);
        chk("err_pulse", 32'(err3), 1);
        chk("err_cmd_ready", 32'(cmd_ready3), 1);
        chk("err_no_wr", 32'(reg_wr3), 0);
        chk("err_in_ready", 32'(in_ready3), 0);
        in_valid = 1; in_data = 8'h99;
        step();
        chk("err_one_cycle", 32'(err3), 0);
        step();
        in_valid = 0;

        rst = 1;
        #2;
        chk("mid_rst_cmd_ready", 32'(cmd_ready), 0);
        chk("mid_rst_in_ready", 32'(in_ready), 0);
        chk("mid_rst_reg_wr", 32'(reg_wr), 0);
        chk("mid_rst_stage", stg_packed(), 0);
        step();
        rst = 0;
        step();
        chk("post_rst_idle", 32'(cmd_ready), 1);
        load(2'd1, 32'h0e0d0c0b, 0);

        repeat (2) step();
        chk("total_wr", 32'(wr_cnt), 3);
        chk("total_done", 32'(done_cnt), 5);
        chk("wr_queue_empty", 32'(exp_wr.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got 0 exp 1");
        $fatal(1);
    end
endmodule

// File: doc/vreg_load_seq.md
VREG_LOAD_SEQ -- requirements
Module: vreg_load_seq

Interface
REQ-001 SHALL have parameter BITS, default 8: element width.
REQ-002 SHALL have parameter N, default 64: elements per vector register.
REQ-003 SHALL have parameter R, default 4: number of vector registers served; RW = max(1, $clog2(R)).
REQ-004 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port cmd_valid, input, 1: command offered.
REQ-007 SHALL have port cmd_ready, output, 1: command accepted when cmd_valid and cmd_ready are both high.
REQ-008 SHALL have port cmd_op, input, 1: 0 = LOAD (stream into a register), 1 = DUMP (stream a register out).
REQ-009 SHALL have port cmd_reg, input, RW: target register index.
REQ-010 SHALL have port in_data, input, BITS: LOAD element.
REQ-011 SHALL have port in_valid, input, 1: LOAD element offered.
REQ-012 SHALL have port in_ready, output, 1: LOAD element accepted on in_valid and in_ready.
REQ-013 SHALL have port stage, output, BITS x N unpacked [N-1:0]: staging vector; drives the vector register inputs.
REQ-014 SHALL have port reg_wr, output, R: one-hot write enable to the vector registers.
REQ-015 SHALL have port rd_sel, output, RW: register select for the external read mux.
REQ-016 SHALL have port vec_in, input, BITS x N unpacked [N-1:0]: selected register contents.
REQ-017 SHALL have port out_data, output, BITS: DUMP element.
REQ-018 SHALL have port out_valid, output, 1: DUMP element offered.
REQ-019 SHALL have port out_ready, input, 1: DUMP element consumed on out_valid and out_ready.
REQ-020 SHALL have port done, output, 1: one-cycle completion pulse.
REQ-021 SHALL have port err, output, 1: one-cycle pulse for cmd_reg >= R.

Function
REQ-022 SHALL implement FSM states IDLE, LOAD, COMMIT, DUMP with an element counter cnt of width $clog2(N) and a latched register index ri.
REQ-023 SHALL drive cmd_ready=1 only in IDLE; on accept, latch cmd_reg into ri, clear cnt, and go to LOAD (op 0) or DUMP (op 1).
REQ-024 SHALL, on accept with cmd_reg >= R, pulse err the following cycle, stay in IDLE, and perform no writes or outputs.
REQ-025 SHALL drive in_ready=1 only in LOAD; each in handshake writes stage[cnt]=in_data and increments cnt.
REQ-026 SHALL, on the in handshake with cnt==N-1, go to COMMIT; cnt wraps to 0.
REQ-027 SHALL, in COMMIT (exactly one cycle), assert reg_wr[ri]=1 with all other bits 0, pulse done, and return to IDLE.
REQ-028 SHALL hold reg_wr=0 in every state other than COMMIT.
REQ-029 SHALL hold stage stable outside LOAD handshakes; stage retains the last loaded vector after COMMIT.
REQ-030 SHALL drive rd_sel=ri at all times; out_valid=1 only in DUMP; out_data=vec_in[cnt] combinationally.
REQ-031 SHALL increment cnt on each out handshake; on the handshake with cnt==N-1, pulse done in that same cycle and return to IDLE.
REQ-032 SHALL leave cnt and outputs unchanged while in_valid=0 in LOAD or out_ready=0 in DUMP (stalls unbounded).
REQ-033 SHALL ignore cmd_valid outside IDLE and in_valid outside LOAD.

Reset
REQ-034 SHALL, on rst=1, asynchronously enter IDLE with cnt=0, ri=0, all stage elements 0, reg_wr=0, done=0, err=0, out_valid=0, in_ready=0, cmd_ready=0 for the duration of reset.
REQ-035 SHALL, on reset asserted mid-LOAD, discard the partial vector with no reg_wr pulse; mid-DUMP, drop out_valid without done.

Verification
REQ-036 SHALL verify: N=4, LOAD reg 2, elements 1,2,3,4 back-to-back -> COMMIT the cycle after the 4th element, reg_wr=4'b0100 for one cycle, done=1, stage={4,3,2,1}.
REQ-037 SHALL verify: LOAD with in_valid toggling 1/0 -> 4 elements accepted in 7 cycles, stage correct, single reg_wr pulse.
REQ-038 SHALL verify: DUMP reg 1, vec_in={40,30,20,10}, out_ready=1 -> rd_sel=1, out_data 10,20,30,40 on consecutive cycles, done with the last element.
REQ-039 SHALL verify: DUMP with out_ready held 0 for 5 cycles -> out_data stays at element 0, cnt unchanged.
REQ-040 SHALL verify: R=3, cmd_reg=3 -> err pulse, no reg_wr, cmd_ready high again the next cycle.
REQ-041 SHALL verify: rst asserted after 2 LOAD elements -> immediate IDLE, stage=0, no reg_wr; a following full LOAD completes normally.
